// File: rtl/alu_cmd_sequencer.sv
// Command sequencer around the external 4-bit ALU: registered operand drive, accumulator, result FIFO.
// Latency: accept -> result after 1 edge (2 with ALU_SETTLE_EN); backpressure: cmd_ready low while busy or FIFO slots are exhausted.
// Optional macro ALU_SETTLE_EN adds a SETTLE state so slow ALU paths get an extra cycle before capture.
module alu_cmd_sequencer #(
   parameter int WIDTH      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic             cmd_use_acc,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [2:0]       alu_s,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_f,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic [WIDTH-1:0] acc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             capture;
   logic             pop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] mem [FIFO_DEPTH];

   assign accept    = cmd_valid & cmd_ready;
   assign res_valid = (count != '0);
   assign pop       = res_valid & res_ready;
   assign res_data  = mem[rd_ptr];
   assign res_zero  = res_valid && (res_data == '0);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = DRIVE;
`ifdef ALU_SETTLE_EN
         DRIVE:   state_nxt = SETTLE;
`else
         DRIVE:   state_nxt = IDLE;
`endif
         SETTLE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Accepting only in IDLE with a free slot reserves room for the later push.
   always_comb begin
      cmd_ready = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE:    cmd_ready = clr && (count < CNT_W'(FIFO_DEPTH));
`ifdef ALU_SETTLE_EN
         SETTLE:  capture = 1'b1;
`else
         DRIVE:   capture = 1'b1;
`endif
         default: begin
            cmd_ready = 1'b0;
            capture   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         alu_s <= '0;
         alu_a <= '0;
         alu_b <= '0;
         acc   <= '0;
      end else begin
         if (accept) begin
            alu_s <= cmd_op;
            alu_b <= cmd_b;
            alu_a <= cmd_use_acc ? acc : cmd_a;
         end
         if (capture) acc <= alu_f;
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({capture, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (capture) mem[wr_ptr] <= alu_f;
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer; models the external ALU combinationally.
module tb_alu_cmd_sequencer;

`ifdef ALU_SETTLE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [3:0] cmd_a = '0;
   logic       cmd_use_acc = 1'b0;
   logic [3:0] cmd_b = '0;
   logic [2:0] alu_s;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_f;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_data;
   logic       res_zero;
   logic [3:0] acc;

   int         vecs = 0;
   int         errs = 0;
   logic [3:0] exp_q[$];
   logic [3:0] mdl_acc = '0;

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
      case (s)
         3'd0:    return 4'h0;
         3'd1:    return b - a;
         3'd2:    return a - b;
         3'd3:    return a + b;
         3'd4:    return a ^ b;
         3'd5:    return a | b;
         3'd6:    return a & b;
         default: return 4'hF;
      endcase
   endfunction

   assign alu_f = alu_fn(alu_s, alu_a, alu_b);

   alu_cmd_sequencer #(.WIDTH(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .clr(clr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a),
      .cmd_use_acc(cmd_use_acc), .cmd_b(cmd_b),
      .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
      .acc(acc)
   );

   // Present a command until accepted; the expected result joins the scoreboard at accept.
   task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic ua, input logic [3:0] b);
      logic [3:0] e;
      bit         ok = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_use_acc = ua; cmd_b = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (ok) begin
         e = alu_fn(op, ua ? mdl_acc : a, b);
         exp_q.push_back(e);
         mdl_acc = e;
         @(posedge clk); #1;
      end else begin
         vecs++; errs++;
         $display("FAIL issue_timeout: cmd_ready=%b never rose, required 1", cmd_ready);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic pop_one(output logic [3:0] d, output bit ok);
      res_ready = 1'b1;
      ok = 1'b0;
      d  = 'x;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_valid) begin d = res_data; ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      clr = 1'b0;
      #13;
      vecs++;
      if ({cmd_ready, res_valid, res_zero} !== 3'b000) begin
         errs++; $display("FAIL reset_flags: rdy/vld/zero=%b required 000", {cmd_ready, res_valid, res_zero});
      end
      vecs++;
      if ({alu_s, alu_a, alu_b, acc} !== 15'd0) begin
         errs++; $display("FAIL reset_regs: s=%0d a=%0d b=%0d acc=%0d required all 0", alu_s, alu_a, alu_b, acc);
      end
      @(posedge clk); #1 clr = 1'b1;
      @(negedge clk);
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      logic [3:0] e;
      res_ready = 1'b1;
      issue(3'd3, 4'd10, 1'b0, 4'd3);
      @(negedge clk);
      vecs++;
      if ({alu_s, alu_a, alu_b, cmd_ready, res_valid} !== {3'd3, 4'd10, 4'd3, 1'b0, 1'b0}) begin
         errs++; $display("FAIL add_drive: s=%0d a=%0d b=%0d rdy=%b vld=%b required 3 10 3 0 0", alu_s, alu_a, alu_b, cmd_ready, res_valid);
      end
      for (int i = 1; i < LAT; i++) begin
         @(negedge clk);
         vecs++;
         if ({cmd_ready, res_valid} !== 2'b00) begin
            errs++; $display("FAIL add_settle: rdy=%b vld=%b required 0 0", cmd_ready, res_valid);
         end
      end
      @(negedge clk);
      e = exp_q.pop_front();
      vecs++;
      if (res_valid !== 1'b1 || res_data !== e || acc !== 4'd13 || res_zero !== 1'b0) begin
         errs++; $display("FAIL add_result: vld=%b data=%0d acc=%0d zero=%b required 1 %0d 13 0", res_valid, res_data, acc, res_zero, e);
      end
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      vecs++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errs++; $display("FAIL add_popped: vld=%b rdy=%b required 0 1", res_valid, cmd_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sub_order;
      logic [3:0] got, e;
      logic [3:0] lit [2];
      bit ok;
      lit[0] = 4'd9; lit[1] = 4'd7;
      issue(3'd1, 4'd10, 1'b0, 4'd3);
      issue(3'd2, 4'd10, 1'b0, 4'd3);
      for (int i = 0; i < 2; i++) begin
         pop_one(got, ok);
         e = exp_q.pop_front();
         vecs++;
         if (!ok || got !== e || got !== lit[i]) begin
            errs++; $display("FAIL sub_order[%0d]: got %0d required %0d", i, got, lit[i]);
         end
      end
   endtask

   task automatic test_chain;
      logic [3:0] got, e;
      bit ok;
      issue(3'd3, 4'd15, 1'b0, 4'd1);
      repeat (LAT + 1) @(negedge clk);
      vecs++;
      if (acc !== 4'd0 || res_zero !== 1'b1 || res_valid !== 1'b1) begin
         errs++; $display("FAIL chain_zero: acc=%0d zero=%b vld=%b required 0 1 1", acc, res_zero, res_valid);
      end
      @(posedge clk); #1;
      issue(3'd3, 4'd9, 1'b1, 4'd5);
      @(negedge clk);
      vecs++;
      if (alu_a !== 4'd0 || alu_b !== 4'd5) begin
         errs++; $display("FAIL chain_acc_operand: a=%0d b=%0d required 0 5", alu_a, alu_b);
      end
      issue(3'd4, 4'd3, 1'b1, 4'hF);
      @(negedge clk);
      vecs++;
      if (alu_a !== 4'd5 || alu_s !== 3'd4) begin
         errs++; $display("FAIL chain_fwd_operand: a=%0d s=%0d required 5 4", alu_a, alu_s);
      end
      repeat (LAT) @(negedge clk);
      vecs++;
      if (acc !== 4'hA) begin
         errs++; $display("FAIL chain_xor: acc=%h required a", acc);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         pop_one(got, ok);
         e = exp_q.pop_front();
         vecs++;
         if (!ok || got !== e) begin
            errs++; $display("FAIL chain_drain[%0d]: got %h required %h", i, got, e);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [3:0] got, e;
      bit ok;
      res_ready = 1'b0;
      issue(3'd3, 4'd0, 1'b0, 4'd1);
      issue(3'd2, 4'd5, 1'b0, 4'd3);
      issue(3'd5, 4'd1, 1'b0, 4'd2);
      issue(3'd6, 4'hC, 1'b0, 4'h4);
      repeat (LAT + 1) @(negedge clk);
      vecs++;
      if (cmd_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 4'd1) begin
         errs++; $display("FAIL bp_full: rdy=%b vld=%b head=%0d required 0 1 1", cmd_ready, res_valid, res_data);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_a = 4'd5; cmd_use_acc = 1'b0; cmd_b = 4'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vecs++;
         if (cmd_ready !== 1'b0) begin
            errs++; $display("FAIL bp_hold[%0d]: rdy=%b required 0", i, cmd_ready);
         end
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      vecs++;
      if (res_data !== e || cmd_ready !== 1'b0) begin
         errs++; $display("FAIL bp_pop_edge: head=%0d rdy=%b required %0d 0", res_data, cmd_ready, e);
      end
      @(posedge clk); #1 res_ready = 1'b0;
      @(negedge clk);
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++; $display("FAIL bp_after_pop: rdy=%b required 1", cmd_ready);
      end
      e = alu_fn(3'd4, 4'd5, 4'd3);
      exp_q.push_back(e);
      mdl_acc = e;
      @(posedge clk); #1 cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pop_one(got, ok);
         e = exp_q.pop_front();
         vecs++;
         if (!ok || got !== e) begin
            errs++; $display("FAIL bp_drain[%0d]: got %0d required %0d", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid_op;
      logic [3:0] got, e;
      bit ok;
      issue(3'd5, 4'd2, 1'b0, 4'd4);
      issue(3'd3, 4'd1, 1'b0, 4'd1);
      #1 clr = 1'b0;
      #1;
      vecs++;
      if (res_valid !== 1'b0 || acc !== 4'd0 || cmd_ready !== 1'b0 || alu_s !== 3'd0) begin
         errs++; $display("FAIL rst_mid: vld=%b acc=%0d rdy=%b s=%0d required 0 0 0 0", res_valid, acc, cmd_ready, alu_s);
      end
      exp_q.delete();
      mdl_acc = '0;
      @(posedge clk); #1 clr = 1'b1;
      repeat (LAT + 1) @(negedge clk);
      vecs++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || acc !== 4'd0) begin
         errs++; $display("FAIL rst_no_push: vld=%b rdy=%b acc=%0d required 0 1 0", res_valid, cmd_ready, acc);
      end
      @(posedge clk); #1;
      issue(3'd7, 4'd0, 1'b0, 4'd0);
      pop_one(got, ok);
      e = exp_q.pop_front();
      vecs++;
      if (!ok || got !== e || got !== 4'hF) begin
         errs++; $display("FAIL rst_allones: got %h required f", got);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_order();
      test_chain();
      test_backpressure();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream/downstream wrapper stage around the team's combinational 4-bit ALU.
- Op encoding: 0 zero, 1 B-A, 2 A-B, 3 A+B, 4 XOR, 5 OR, 6 AND, 7 all-ones.
- Accepts operation commands over valid/ready and drives the ALU's select and operand inputs from registers.
- Samples the ALU result into an accumulator and a result FIFO, which is drained over a second valid/ready port.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_op  in  3  ALU opcode
- cmd_a  in  WIDTH  operand A, used when cmd_use_acc=0
- cmd_use_acc  in  1  1: A operand = current accumulator
- cmd_b  in  WIDTH  operand B
- alu_s  out  3  to ALU select
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_f  in  WIDTH  from ALU result
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer pops head when res_valid & res_ready at a rising edge
- res_data  out  WIDTH  FIFO head
- res_zero  out  1  res_data == 0; 0 when FIFO empty
- acc  out  WIDTH  accumulator (last captured result)

Behaviour:
- Reset (clr=0, asynchronous, any state): state=IDLE, alu_s=0, alu_a=0, alu_b=0, acc=0, FIFO pointers and count=0.
  - Reset forces res_valid=0, res_zero=0 and cmd_ready=0 while clr=0.
  - A command in flight is discarded.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, DRIVE (plus SETTLE, see optional feature).
  - IDLE: cmd_ready = (count + inflight < FIFO_DEPTH); inflight is always 0 in IDLE, so this reduces to count < FIFO_DEPTH.
    - On accept: alu_s<=cmd_op; alu_b<=cmd_b; alu_a<=(cmd_use_acc ? acc : cmd_a); go to DRIVE.
  - DRIVE: cmd_ready=0; ALU inputs held stable.
    - At the end of the cycle: acc<=alu_f, push alu_f into the FIFO, return to IDLE.
- Timing and throughput:
  - Latency: command accepted at edge E0 -> result in acc and res_valid=1 after edge E1.
  - Throughput: one command per 2 cycles.
- ALU inputs keep their last values in IDLE; there is no glitching back to 0.
- Slot reservation: the accept condition reserves a FIFO slot, so a push in DRIVE can never overflow.
  - Simultaneous push and pop in the same cycle: count unchanged, data order preserved.
- Pop: with FIFO empty, res_ready is ignored. Pop when res_valid & res_ready; read pointer wraps modulo FIFO_DEPTH.
- Full FIFO: cmd_ready=0 until a pop occurs. A pop at edge E allows accept at the following edge; there is no same-edge bypass.
- Arithmetic: wrap modulo 2^WIDTH is done by the ALU; this block stores alu_f bit-exact.
- cmd_use_acc=1 uses the accumulator value at accept time, including a result captured on the immediately preceding edge.
- cmd_* inputs are ignored outside IDLE; the upstream must hold cmd_valid until accepted.

Optional Feature:
- Macro: ALU_SETTLE_EN
- Defined: extra SETTLE state between DRIVE and capture for slow/multicycle ALU paths.
  - Sequence is IDLE -> DRIVE -> SETTLE -> IDLE; capture occurs at the end of SETTLE.
  - Latency: accept E0 -> result after E2; throughput 1 per 3 cycles.
  - cmd_ready=0 in SETTLE.
- Undefined: 2-state behaviour as above.

Test Plan:
- Reset, then op=3 A=10 B=3 use_acc=0 with res_ready=1 -> alu_s=3, alu_a=10, alu_b=3 in DRIVE; acc=13 and res_data=13 one edge later; res_zero=0.
- op=1 A=10 B=3 -> res_data=9 (3-10 mod 16); op=2 same operands -> 7; results pop in order 9, 7.
- Chain: op=3 A=15 B=1 -> acc=0, res_zero=1; then op=3 use_acc=1 B=5 -> alu_a=0, acc=5; then op=4 use_acc=1 B=4'hF -> acc=4'hA.
- Backpressure: res_ready=0, issue 4 commands with results 1, 2, 3, 4 -> count=4 and cmd_ready=0. Hold a 5th command -> not accepted. Assert res_ready for 1 cycle -> pop 1; 5th accepted on the next edge; remaining order is 2, 3, 4, 5th.
- Reset mid-op: assert clr=0 during DRIVE -> FIFO empties, acc=0, no push. After release, op=7 -> res_data=4'hF.
- With ALU_SETTLE_EN defined: repeat the first scenario -> result appears exactly one edge later than without the macro; cmd_ready stays low for 2 cycles after accept.
